// File: rtl/worley_noise_pipe.sv
// Worley (cellular) noise: tracks NUM_POINTS drifting feature points, outputs F1/F2-derived noise and nearest cell id.
// Latency 3 cycles, one pixel per cycle, no backpressure. Optional F2 tracking under macro WORLEY_F2_EN.
module worley_noise_pipe #(
    parameter int NUM_POINTS = 4,
    parameter int COORD_W    = 10,
    parameter int OUT_W      = 8,
    parameter int DIST_SHIFT = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_tick,
    input  logic                in_valid,
    input  logic [COORD_W-1:0]  x,
    input  logic [COORD_W-1:0]  y,
    input  logic [1:0]          mode,
    output logic                out_valid,
    output logic [OUT_W-1:0]    noise,
    output logic [(($clog2(NUM_POINTS) > 1) ? $clog2(NUM_POINTS) : 1)-1:0] cell_id
);
    localparam int CID_W = ($clog2(NUM_POINTS) > 1) ? $clog2(NUM_POINTS) : 1;
    localparam int DW    = 2 * COORD_W + 1;
    localparam logic [DW-1:0] SAT = DW'((1 << OUT_W) - 1);

    logic [COORD_W-1:0] px_q [NUM_POINTS];
    logic [COORD_W-1:0] py_q [NUM_POINTS];
    logic [COORD_W-1:0] px_d [NUM_POINTS];
    logic [COORD_W-1:0] py_d [NUM_POINTS];

    logic [COORD_W:0]   sx   [NUM_POINTS];
    logic [COORD_W:0]   sy   [NUM_POINTS];
    logic [COORD_W-1:0] dx_d [NUM_POINTS];
    logic [COORD_W-1:0] dy_d [NUM_POINTS];
    logic [COORD_W-1:0] dx_q [NUM_POINTS];
    logic [COORD_W-1:0] dy_q [NUM_POINTS];
    logic [1:0]         mode1_q;
    logic               vld1_q;

    logic [DW-1:0]      d_d  [NUM_POINTS];
    logic [DW-1:0]      d_q  [NUM_POINTS];
    logic [1:0]         mode2_q;
    logic               vld2_q;

    logic [DW-1:0]      f1;
    logic [CID_W-1:0]   f1_idx;
`ifdef WORLEY_F2_EN
    logic [DW-1:0]      f2;
`endif
    logic [DW-1:0]      sel;
    logic [DW-1:0]      scaled;
    logic [OUT_W-1:0]   noise_d;

    logic               out_valid_q;
    logic [OUT_W-1:0]   noise_q;
    logic [CID_W-1:0]   cell_id_q;

    // Even points drift in x by +(i/2+1), odd by -(i/2+1); every third point drifts up in y.
    always_comb begin
        for (int i = 0; i < NUM_POINTS; i++) begin
            px_d[i] = px_q[i];
            py_d[i] = py_q[i];
            if (frame_tick) begin
                if (i % 2 == 0) px_d[i] = px_q[i] + COORD_W'(i / 2 + 1);
                else            px_d[i] = px_q[i] - COORD_W'(i / 2 + 1);
                if (i % 3 == 0) py_d[i] = py_q[i] - COORD_W'(1);
                else            py_d[i] = py_q[i] + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_POINTS; i++) begin
                px_q[i] <= COORD_W'(100 + 211 * i);
                py_q[i] <= COORD_W'(60 + 137 * i);
            end
        end else begin
            for (int i = 0; i < NUM_POINTS; i++) begin
                px_q[i] <= px_d[i];
                py_q[i] <= py_d[i];
            end
        end
    end

    // Signed differences one bit wider than the coordinate, folded to magnitudes (planar, not toroidal).
    always_comb begin
        for (int i = 0; i < NUM_POINTS; i++) begin
            sx[i]   = {1'b0, x} - {1'b0, px_q[i]};
            sy[i]   = {1'b0, y} - {1'b0, py_q[i]};
            dx_d[i] = sx[i][COORD_W] ? COORD_W'(-sx[i]) : sx[i][COORD_W-1:0];
            dy_d[i] = sy[i][COORD_W] ? COORD_W'(-sy[i]) : sy[i][COORD_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_POINTS; i++) begin
                dx_q[i] <= '0;
                dy_q[i] <= '0;
            end
            mode1_q <= '0;
            vld1_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_POINTS; i++) begin
                dx_q[i] <= dx_d[i];
                dy_q[i] <= dy_d[i];
            end
            mode1_q <= mode;
            vld1_q  <= in_valid;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_POINTS; i++) begin
            d_d[i] = DW'(dx_q[i]) * DW'(dx_q[i]) + DW'(dy_q[i]) * DW'(dy_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_POINTS; i++) d_q[i] <= '0;
            mode2_q <= '0;
            vld2_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_POINTS; i++) d_q[i] <= d_d[i];
            mode2_q <= mode1_q;
            vld2_q  <= vld1_q;
        end
    end

    // Strict less-than keeps the lowest index on ties; a tie with F1 then lands in F2.
    always_comb begin
        f1     = d_q[0];
        f1_idx = '0;
`ifdef WORLEY_F2_EN
        f2     = '1;
`endif
        for (int i = 1; i < NUM_POINTS; i++) begin
            if (d_q[i] < f1) begin
`ifdef WORLEY_F2_EN
                f2 = f1;
`endif
                f1     = d_q[i];
                f1_idx = CID_W'(i);
            end
`ifdef WORLEY_F2_EN
            else if (d_q[i] < f2) begin
                f2 = d_q[i];
            end
`endif
        end
    end

    always_comb begin
`ifdef WORLEY_F2_EN
        case (mode2_q)
            2'd1:    sel = f2;
            2'd2:    sel = f2 - f1;
            default: sel = f1;
        endcase
`else
        sel = f1;
`endif
        scaled  = sel >> DIST_SHIFT;
        noise_d = '0;
        if (mode2_q == 2'd3) begin
            noise_d[OUT_W-1 -: CID_W] = f1_idx;
        end else if (scaled > SAT) begin
            noise_d = '1;
        end else begin
            noise_d = scaled[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            noise_q     <= '0;
            cell_id_q   <= '0;
        end else begin
            out_valid_q <= vld2_q;
            if (vld2_q) begin
                noise_q   <= noise_d;
                cell_id_q <= f1_idx;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign noise     = noise_q;
    assign cell_id   = cell_id_q;

endmodule

// File: tb/tb_worley_noise_pipe.sv
// Self-checking bench for worley_noise_pipe: table vectors, motion/wrap/streaming/reset sequences, queue scoreboard.
module tb_worley_noise_pipe;
    localparam int NP = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic       in_valid;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] mode;
    logic       out_valid;
    logic [7:0] noise;
    logic [1:0] cell_id;

    worley_noise_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_tick(frame_tick),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .mode      (mode),
        .out_valid (out_valid),
        .noise     (noise),
        .cell_id   (cell_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int m;
        int exp_noise;
        int exp_cid;
    } vec_t;

    typedef struct {
        int noise;
        int cid;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   m_px [NP];
    int   m_py [NP];
    vec_t tbl [10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NP; i++) begin
            m_px[i] = (100 + 211 * i) % 1024;
            m_py[i] = (60 + 137 * i) % 1024;
        end
    endfunction

    function automatic void model_tick();
        for (int i = 0; i < NP; i++) begin
            m_px[i] = (m_px[i] + ((i % 2 == 0) ? (i / 2 + 1) : -(i / 2 + 1))) & 1023;
            m_py[i] = (m_py[i] + ((i % 3 == 0) ? -1 : 1)) & 1023;
        end
    endfunction

    function automatic void model_calc(input int px, input int py, input int m,
                                       output int nz, output int cid);
        int d [NP];
        int f1, f2, v, mm, dx, dy;
        cid = 0;
        for (int i = 0; i < NP; i++) begin
            dx = px - m_px[i];
            dy = py - m_py[i];
            if (dx < 0) dx = -dx;
            if (dy < 0) dy = -dy;
            d[i] = dx * dx + dy * dy;
        end
        for (int i = 1; i < NP; i++) if (d[i] < d[cid]) cid = i;
        f1 = d[cid];
        f2 = 32'h7fffffff;
        for (int j = 0; j < NP; j++) if (j != cid && d[j] < f2) f2 = d[j];
        mm = m;
`ifndef WORLEY_F2_EN
        if (mm == 1 || mm == 2) mm = 0;
`endif
        case (mm)
            1:       v = f2 >> 6;
            2:       v = (f2 - f1) >> 6;
            default: v = f1 >> 6;
        endcase
        if (v > 255) v = 255;
        nz = (mm == 3) ? (cid << 6) : v;
    endfunction

    task automatic drive(input int px, input int py, input int m, input bit tick,
                         input int en, input int ec);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid   = 1'b1;
        frame_tick = tick;
        x          = 10'(px);
        y          = 10'(py);
        mode       = 2'(m);
        e.noise = en;
        e.cid   = ec;
        e.cyc   = cyc + 3;
        sb.push_back(e);
        if (tick) model_tick();
    endtask

    task automatic drive_model(input int px, input int py, input int m, input bit tick);
        int en, ec;
        model_calc(px, py, m, en, ec);
        drive(px, py, m, tick, en, ec);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            in_valid   = 1'b0;
            frame_tick = 1'b0;
        end
    endtask

    task automatic tick_only();
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        frame_tick = 1'b1;
        model_tick();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        frame_tick = 1'b0;
        rst_n      = 1'b0;
        sb.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        check(name, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("noise", int'(noise), e.noise);
                check("cell_id", int'(cell_id), e.cid);
                check("latency_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
`ifdef WORLEY_F2_EN
        tbl[0] = '{100,  60,  0, 0,   0};
        tbl[1] = '{311,  197, 0, 0,   1};
        tbl[2] = '{140,  60,  0, 25,  0};
        tbl[3] = '{140,  60,  1, 255, 0};
        tbl[4] = '{140,  60,  2, 255, 0};
        tbl[5] = '{522,  334, 3, 128, 2};
        tbl[6] = '{733,  471, 3, 192, 3};
        tbl[7] = '{0,    0,   0, 212, 0};
        tbl[8] = '{100,  60,  2, 255, 0};
        tbl[9] = '{1023, 1023, 0, 255, 3};
`else
        tbl[0] = '{100,  60,  0, 0,   0};
        tbl[1] = '{311,  197, 0, 0,   1};
        tbl[2] = '{140,  60,  0, 25,  0};
        tbl[3] = '{140,  60,  1, 25,  0};
        tbl[4] = '{140,  60,  2, 25,  0};
        tbl[5] = '{522,  334, 3, 128, 2};
        tbl[6] = '{733,  471, 3, 192, 3};
        tbl[7] = '{0,    0,   0, 212, 0};
        tbl[8] = '{100,  60,  2, 0,   0};
        tbl[9] = '{1023, 1023, 0, 255, 3};
`endif
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        frame_tick = 1'b0;
        x          = '0;
        y          = '0;
        mode       = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_noise", int'(noise), 0);
        check("reset_cell_id", int'(cell_id), 0);
        rst_n = 1'b1;

        // Table vectors, applied back-to-back.
        for (int i = 0; i < 10; i++)
            drive(tbl[i].x, tbl[i].y, tbl[i].m, 1'b0, tbl[i].exp_noise, tbl[i].exp_cid);
        idle(1);
        drain("drain_table");
        idle(3);
        check("hold_noise_after_idle", int'(noise), 255);
        check("hold_cell_id_after_idle", int'(cell_id), 3);

        // Tick coincident with a query sees the old position; next query sees the moved point.
        drive(100, 60, 0, 1'b1, 0, 0);
        drive(101, 59, 0, 1'b0, 0, 0);
        drive_model(140, 60, 1, 1'b0);
        idle(1);
        drain("drain_motion");

        // Wrap of point 0 x after 924 ticks.
        do_reset();
        for (int i = 0; i < 924; i++) tick_only();
        drive(0, 160, 0, 1'b0, 0, 0);
        drive_model(411, 97, 3, 1'b0);
        idle(1);
        drain("drain_wrap");

        // Sixteen back-to-back pixels with mode cycling.
        for (int i = 0; i < 16; i++)
            drive_model($urandom_range(0, 1023), $urandom_range(0, 1023), i % 4, 1'b0);
        idle(1);
        drain("drain_stream");

        // Reset while pixels are in flight.
        for (int i = 0; i < 5; i++) drive_model(100 + i, 60, i % 4, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        sb.delete();
        #1;
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_noise", int'(noise), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle(6);
        drive(522, 334, 3, 1'b0, 128, 2);
        idle(1);
        drain("drain_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
